// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-transfer op encodings, sequencer states
// and the datapath width constants used by the register-file access path.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MOV   = 2'b10,
        OP_SWAP  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR_A,
        WR_B,
        DONE
    } xfer_state_e;

endpackage

// File: rtl/reg_xfer.sv
// Register-transfer sequencer: takes one READ/WRITE/MOV/SWAP command at a
// time and drives the register file's address/read/write/data port.
module reg_xfer
    import cpu_pkg::op_e;
    import cpu_pkg::OP_READ;
    import cpu_pkg::OP_WRITE;
    import cpu_pkg::OP_MOV;
    import cpu_pkg::OP_SWAP;
    import cpu_pkg::xfer_state_e;
    import cpu_pkg::IDLE;
    import cpu_pkg::RD_A;
    import cpu_pkg::RD_B;
    import cpu_pkg::WR_A;
    import cpu_pkg::WR_B;
    import cpu_pkg::DONE;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned SEL_W  = cpu_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_src,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_done,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_read,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    xfer_state_e       state_q, state_d;
    op_e               op_q, op_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic [SEL_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_done_q, rsp_done_d;

    logic              rd_en;
    logic              wr_en;
    logic [SEL_W-1:0]  addr_sel;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        dst_d    = dst_q;
        imm_d    = imm_q;
        tmp_a_d  = tmp_a_q;
        tmp_b_d  = tmp_b_q;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        addr_sel = '0;
        wdata    = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    imm_d   = cmd_imm;
                    state_d = (op_e'(cmd_op) == OP_WRITE) ? WR_A : RD_A;
                end
            end
            RD_A: begin
                rd_en    = 1'b1;
                addr_sel = src_q;
                tmp_a_d  = rf_rdata;
                case (op_q)
                    OP_READ: state_d = DONE;
                    OP_MOV:  state_d = WR_A;
                    OP_SWAP: state_d = RD_B;
                    default: state_d = DONE;
                endcase
            end
            RD_B: begin
                rd_en    = 1'b1;
                addr_sel = dst_q;
                tmp_b_d  = rf_rdata;
                state_d  = WR_A;
            end
            WR_A: begin
                wr_en    = 1'b1;
                addr_sel = dst_q;
                wdata    = (op_q == OP_WRITE) ? imm_q : tmp_a_q;
                state_d  = (op_q == OP_SWAP) ? WR_B : DONE;
            end
            WR_B: begin
                wr_en    = 1'b1;
                addr_sel = src_q;
                wdata    = tmp_b_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response is registered on entry to DONE; for READ the capture and
        // the DONE entry share an edge, so take the just-sampled tmp_a_d.
        rsp_done_d = (state_d == DONE);
        rsp_data_d = (state_d == DONE) ? tmp_a_d : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_READ;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            tmp_a_q    <= '0;
            tmp_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            tmp_a_q    <= tmp_a_d;
            tmp_b_q    <= tmp_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_done_q <= rsp_done_d;
        end
    end

    // Strobes are gated by reset so no register-file write lands on a reset edge.
    assign rf_read   = rd_en & ~rst;
    assign rf_write  = wr_en & ~rst;
    assign rf_addr   = {{(ADDR_W-SEL_W){1'b0}}, addr_sel};
    assign rf_wdata  = wdata;
    assign cmd_ready = (state_q == IDLE);
    assign rsp_done  = rsp_done_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/reg_xfer.md
# reg_xfer

Register-transfer sequencer: the initiator side of the 16-byte CPU register file's access port. Accepts one command at a time over a valid/ready handshake and drives the register file's `addr`/`read`/`write`/`in` signals, and samples its `data` output. Supports READ, WRITE-immediate, MOV and SWAP. Sits between the control unit and the register file.

## Interface
- `DATA_W`, 8, register width.
- `ADDR_W`, 8, register-file address width.
- `SEL_W`, 4, register select width; `rf_addr = {(ADDR_W-SEL_W)'b0, sel}`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  2  00 READ, 01 WRITE, 10 MOV, 11 SWAP.
- `cmd_src`  in  SEL_W  source register.
- `cmd_dst`  in  SEL_W  destination register.
- `cmd_imm`  in  DATA_W  immediate for WRITE.
- `rsp_done`  out  1  one-cycle pulse when command completes.
- `rsp_data`  out  DATA_W  value read from `src` (READ, MOV, SWAP); holds until next completion.
- `rf_addr`  out  ADDR_W  register-file address.
- `rf_read`  out  1  register-file read enable.
- `rf_write`  out  1  register-file write enable.
- `rf_wdata`  out  DATA_W  register-file write data.
- `rf_rdata`  in  DATA_W  register-file read data; combinational from `rf_addr` while `rf_read`=1, Z otherwise.

## Operation
- FSM states: IDLE, RD_A, RD_B, WR_A, WR_B, DONE.
- Accept: on a posedge with `cmd_valid && cmd_ready`. On that edge, latch op/src/dst/imm. Commands are never queued.
- IDLE next state on accept: READ→RD_A; WRITE→WR_A; MOV→RD_A; SWAP→RD_A.
- RD_A:
  - `rf_read`=1, `rf_addr`=src.
  - Capture `rf_rdata` into `tmp_a` at the edge.
  - Next state: READ→DONE; MOV→WR_A; SWAP→RD_B.
- RD_B (SWAP only):
  - `rf_read`=1, `rf_addr`=dst.
  - Capture into `tmp_b`.
  - Next state: WR_A.
- WR_A:
  - `rf_write`=1, `rf_addr`=dst.
  - `rf_wdata`: `imm` for WRITE, `tmp_a` for MOV/SWAP.
  - Next state: SWAP→WR_B; others→DONE.
- WR_B:
  - `rf_write`=1, `rf_addr`=src, `rf_wdata`=`tmp_b`.
  - Next state: DONE.
- DONE:
  - `rsp_done`=1.
  - `rsp_data`=`tmp_a` (unchanged for WRITE).
  - Next state: IDLE.
- `rf_read` and `rf_write` are never high in the same cycle.
- `rf_rdata` is sampled only in RD_A/RD_B; Z values outside those states are ignored.
- Outside RD/WR states: `rf_addr`=0 and `rf_wdata`=0.
- SWAP with src==dst is legal. It performs both writes, and the register value is unchanged.
- Reset:
  - State→IDLE; `tmp_a`, `tmp_b`, `rsp_data`→0.
  - All outputs 0 except `cmd_ready`, which is 1 after the reset edge.
  - `rf_write` and `rf_read` are gated with `!rst`. No register-file write occurs on any edge where `rst`=1, including mid-SWAP. A SWAP aborted between WR_A and WR_B leaves dst written and src untouched; this is accepted behaviour.

## Timing
- Cycle 0 = accept edge. Latency from accept to `rsp_done`:
  - READ: 2 cycles (RD_A, DONE).
  - WRITE: 2 cycles.
  - MOV: 3 cycles.
  - SWAP: 5 cycles.
- `cmd_ready` returns high in the cycle after DONE.
- Maximum throughput: one READ/WRITE every 3 cycles.
- Register-file writes land on the posedge ending the WR state. A read in a following state sees the new value.
- `rsp_done` and `rsp_data` are registered outputs, valid in the DONE cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - Op encodings: `OP_READ`, `OP_WRITE`, `OP_MOV`, `OP_SWAP`.
  - The `reg_xfer` state enum.
  - `DATA_W` and `SEL_W` constants.
- No sub-module. Single FSM plus datapath latches.
- The bench pairs this block with the existing 16-byte register file model.

## Test plan
- Reset, then WRITE imm=8'hA5 dst=3, then READ src=3 → `rf_write` pulse at cycle 1 with addr 8'h03; READ `rsp_data`=8'hA5 with `rsp_done` 2 cycles after accept.
- R5=8'h3C, then MOV src=5 dst=9 → R9=8'h3C, R5 unchanged, `rsp_data`=8'h3C, done 3 cycles after accept.
- R1=8'h11, R2=8'h22, then SWAP src=1 dst=2 → R1=8'h22, R2=8'h11, `rsp_done` at cycle 5; SWAP src=dst=7 leaves R7 intact.
- Hold `cmd_valid` high continuously with alternating ops → `cmd_ready` low throughout each command, no command lost or duplicated, and `rf_read`/`rf_write` never both high.
- Assert `rst` in the WR_B cycle of a SWAP → no write on that edge, FSM in IDLE, `rsp_done` never pulses, and the next command is accepted normally.
- WRITE to R15 (`SEL_W` boundary) then READ it → `rf_addr`=8'h0F, and the value round-trips.
